pipeline_controller: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It clears the reset-less pipeline registers after reset and detects load-use hazards. It also handles taken-branch flushes and freezes the whole pipe while data memory is busy. It drives the write-enable and flush inputs of PC and the pipeline registers and sits beside `instructionControl` in the ID stage.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 17 +
 rtl/pipeline_controller.sv | 141 ++++++++++++++
 tb/tb_pipeline_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and widths for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StFill    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  localparam int unsigned CntWidth = 16;
  localparam int unsigned RegWidth = 5;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [RegWidth-1:0] id_rs,
  input  logic [RegWidth-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [RegWidth-1:0] ex_rt,
  output logic                hazard
);

  // $zero is hardwired, so a load targeting it never produces a value to wait for.
  assign hazard = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: post-reset fill, load-use stalls, branch flushes,
// data-memory freeze with timeout, and halt.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 4,
  parameter int unsigned WAIT_MAX    = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RegWidth-1:0] id_rs,
  input  logic [RegWidth-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [RegWidth-1:0] ex_rt,
  input  logic                mem_branch_taken,
  input  logic                dmem_busy,
  input  logic                halt_req,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic                pipe_freeze,
  output logic [1:0]          state,
  output logic [15:0]         stall_count,
  output logic                mem_timeout
);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] fill_q, fill_d;
  logic [CntWidth-1:0] wait_q, wait_d;
  logic [CntWidth-1:0] stall_q, stall_d;
  logic                timeout_q, timeout_d;
  logic                hazard;
  logic                active;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  assign active = (state_q == StRun) || (state_q == StMemWait);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StFill;
      fill_q    <= CntWidth'(FILL_CYCLES - 1);
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StFill: begin
        if (fill_q == '0) state_d = StRun;
        else              fill_d  = fill_q - 1'b1;
      end
      StRun, StMemWait: begin
        if (dmem_busy) begin
          if (state_q == StRun) begin
            state_d = StMemWait;
            wait_d  = CntWidth'(1);
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_q >= CntWidth'(WAIT_MAX - 1)) begin
              timeout_d = 1'b1;
              state_d   = StHalt;
            end
          end
        end else if (!mem_branch_taken && !hazard && halt_req) begin
          state_d = StHalt;
        end else begin
          state_d = StRun;
        end
      end
      StHalt: state_d = StHalt;
    endcase
  end

  // Once busy drops in MEM_WAIT the cycle is handled exactly like RUN, so the
  // freeze lasts only as long as busy is high.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    unique case (state_q)
      StFill: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      StRun, StMemWait: begin
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
        end else if (mem_branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (hazard || halt_req) begin
          idex_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      StHalt: idex_flush = 1'b1;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (active && !pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  assign state       = state_q;
  assign stall_count = stall_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with hand-computed expectations.
module tb_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, mem_branch_taken, dmem_busy, halt_req;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_controller #(
    .FILL_CYCLES (4),
    .WAIT_MAX    (64)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .dmem_busy        (dmem_busy),
    .halt_req         (halt_req),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .pipe_freeze      (pipe_freeze),
    .state            (state),
    .stall_count      (stall_count),
    .mem_timeout      (mem_timeout)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven just after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_load_use(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                              input logic [4:0] rt, input logic uses_rt);
    ex_mem_read = rd;
    ex_rt       = ert;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = uses_rt;
  endtask

  initial begin
    reset = 1'b0;
    set_load_use(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    mem_branch_taken = 1'b0;
    dmem_busy        = 1'b0;
    halt_req         = 1'b0;

    tick(2);
    sample();
    check_eq("reset_state", state, 2'd0);
    check_eq("reset_stall", stall_count, 16'd0);
    check_eq("reset_timeout", mem_timeout, 1'b0);

    // Fill: four cycles of flush, then RUN.
    tick(1);
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      sample();
      check_eq($sformatf("fill%0d_pc_write", c), pc_write, 1'b0);
      check_eq($sformatf("fill%0d_flushes", c), {ifid_flush, idex_flush, exmem_flush}, 3'b111);
      tick(1);
    end
    sample();
    check_eq("run_state", state, 2'd1);
    check_eq("run_pc_write", pc_write, 1'b1);

    // lw $2 in EX, add $3,$2,$4 in ID: one-cycle stall.
    tick(1);
    set_load_use(1'b1, 5'd2, 5'd2, 5'd4, 1'b1);
    sample();
    check_eq("lu_pc_write", pc_write, 1'b0);
    check_eq("lu_idex_flush", idex_flush, 1'b1);
    check_eq("lu_ifid_write", ifid_write, 1'b0);
    tick(1);
    set_load_use(1'b0, 5'd0, 5'd2, 5'd4, 1'b1);
    sample();
    check_eq("lu_release_pc_write", pc_write, 1'b1);
    check_eq("lu_stall_count", stall_count, 16'd1);

    // Load into $zero never stalls.
    tick(1);
    set_load_use(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    sample();
    check_eq("lu_zero_pc_write", pc_write, 1'b1);

    // rt match only counts when ID reads rt.
    tick(1);
    set_load_use(1'b1, 5'd4, 5'd2, 5'd4, 1'b0);
    sample();
    check_eq("lu_rt_unused_pc_write", pc_write, 1'b1);
    tick(1);
    set_load_use(1'b1, 5'd4, 5'd2, 5'd4, 1'b1);
    sample();
    check_eq("lu_rt_used_pc_write", pc_write, 1'b0);
    tick(1);
    check_eq("lu_rt_stall_count", stall_count, 16'd2);

    // Branch taken together with a hazard: branch wins.
    mem_branch_taken = 1'b1;
    sample();
    check_eq("br_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    check_eq("br_writes", {pc_write, ifid_write}, 2'b11);
    tick(1);
    mem_branch_taken = 1'b0;
    set_load_use(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    sample();
    check_eq("br_stall_count", stall_count, 16'd2);

    // Three busy cycles, with a pending branch that busy must override.
    tick(1);
    dmem_busy        = 1'b1;
    mem_branch_taken = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      sample();
      check_eq($sformatf("busy%0d_freeze", c), pipe_freeze, 1'b1);
      check_eq($sformatf("busy%0d_pc_write", c), pc_write, 1'b0);
      check_eq($sformatf("busy%0d_state", c), state, (c == 1) ? 2'd1 : 2'd2);
      tick(1);
    end
    dmem_busy        = 1'b0;
    mem_branch_taken = 1'b0;
    sample();
    check_eq("busy_end_freeze", pipe_freeze, 1'b0);
    check_eq("busy_end_state", state, 2'd2);
    tick(1);
    check_eq("busy_back_run", state, 2'd1);
    check_eq("busy_stall_count", stall_count, 16'd5);

    // Halt with a hazard: hazard wins, stay in RUN.
    set_load_use(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    halt_req = 1'b1;
    tick(1);
    check_eq("halt_hazard_state", state, 2'd1);
    set_load_use(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    sample();
    check_eq("halt_req_pc_write", pc_write, 1'b0);
    tick(1);
    halt_req = 1'b0;
    sample();
    check_eq("halt_state", state, 2'd3);
    check_eq("halt_idex_flush", idex_flush, 1'b1);
    tick(3);
    sample();
    check_eq("halt_hold_state", state, 2'd3);
    check_eq("halt_hold_pc_write", pc_write, 1'b0);
    check_eq("halt_stall_count", stall_count, 16'd7);

    // Reset out of HALT, refill, then hold busy until timeout.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    sample();
    check_eq("rst2_state", state, 2'd0);
    check_eq("rst2_stall", stall_count, 16'd0);
    tick(4);
    check_eq("rst2_run", state, 2'd1);
    dmem_busy = 1'b1;
    tick(63);
    sample();
    check_eq("to_pre_state", state, 2'd2);
    check_eq("to_pre_flag", mem_timeout, 1'b0);
    tick(1);
    check_eq("to_state", state, 2'd3);
    check_eq("to_flag", mem_timeout, 1'b1);
    check_eq("to_stall_count", stall_count, 16'd64);
    check_eq("to_halt_freeze", pipe_freeze, 1'b0);

    reset = 1'b0;
    tick(1);
    sample();
    check_eq("rst3_state", state, 2'd0);
    check_eq("rst3_flag", mem_timeout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
